finger_count_encoder: RTL and testbench
=======================================

Name: finger_count_encoder

Overview:
- Inverse of the hand-state-to-number converters: takes a number and a counting scheme, and drives a 5-bit hand-state pattern (bit0 = thumb … bit4 = little finger).
- Raises the fingers one at a time at a fixed step rate, holds the final pattern, then signals completion.
- Feeds the hand display / animation path, and provides stimulus for round-trip checks against the converters.

Parameters:
- STEP_CYCLES, 4, clock cycles between successive finger raises (≥1)
- HOLD_CYCLES, 8, cycles the completed pattern is held with hs_valid high (≥1)

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request strobe
- in_ready  out  1  high only in IDLE
- in_num  in  4  number to show
- in_mode  in  1  0 = unary scheme, 1 = binary scheme
- abort  in  1  synchronous cancel
- hs  out  5  hand-state pattern
- hs_valid  out  1  high while the final pattern is held
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse on a rejected request

Behaviour:
- Clocking/reset: one clock, clk. Reset rst_n is asynchronous, active-low. During reset: state = IDLE, hs = 5'b0, hs_valid = 0, done = 0, err = 0, in_ready = 1, step counter = 0, hold counter = 0.
- Target mapping:
  - mode 0: target = (1 << in_num) − 1. Legal only for in_num 0..5; e.g. 3 → 5'b00111, 5 → 5'b11111.
  - mode 1: target = {1'b0, in_num}. All values 0..15 are legal.
- Accept: a request is accepted on a rising edge with in_valid & in_ready. in_num and in_mode are registered at that edge; later input changes are ignored.
- Illegal request (mode 0 and in_num > 5):
  - err = 1 for exactly the next cycle, state stays IDLE, hs unchanged (0).
  - in_ready remains 1, so a new request may be accepted in the err cycle.
- State IDLE: in_ready = 1, hs = 0. On a legal accept:
  - target = 0 → go to HOLD.
  - otherwise → go to RAISE.
  - Both clear the step counter.
- State RAISE: in_ready = 0, hs_valid = 0.
  - The step counter increments every cycle.
  - At the edge where the counter equals STEP_CYCLES−1: OR the lowest target bit not yet set in hs into hs, and clear the counter.
  - If the updated hs equals target, go to HOLD.
  - hs therefore equals target exactly popcount(target) × STEP_CYCLES cycles after RAISE is entered.
  - hs only ever gains bits, lowest first.
- State HOLD: hs = target, hs_valid = 1 for exactly HOLD_CYCLES cycles, then go to DONE.
- State DONE (one cycle): done = 1, hs_valid = 0, hs still = target, in_ready = 0. Next state IDLE, where hs clears to 0.
- abort:
  - Sampled at every edge; in RAISE, HOLD or DONE it forces IDLE next cycle with hs = 0, counters cleared, and no done or err.
  - abort has priority over all transitions.
  - abort in IDLE has no effect, and a request presented in the same cycle is still accepted.
- Reset mid-operation: immediately returns all outputs to their reset values, with no done pulse.
- Outputs are all registered; there is no combinational path from inputs to outputs, except in_ready, which is decoded from state only.

Test Plan (STEP_CYCLES = 2, HOLD_CYCLES = 3):
- Unary 3: mode 0, num 3.
  - hs steps 00001 → 00011 → 00111, one change every 2 cycles.
  - hs_valid high for 3 cycles, then a single done pulse, then hs = 0 and in_ready = 1.
- Binary 10: mode 1, num 10.
  - hs goes 00010 → 01010; target reached 4 cycles after RAISE entry.
  - Hold lasts 3 cycles, then done.
- Zero: mode 0, num 0 → HOLD entered immediately; hs = 0, hs_valid high 3 cycles, then done.
- Illegal: mode 0, num 7 → err is a single pulse, hs stays 0, in_ready stays 1.
  - A request mode 1, num 1 presented in the err cycle is accepted.
- Abort and reset mid-operation:
  - mode 0, num 5 with abort asserted after the 2nd raise (hs = 00011) → next cycle hs = 0, IDLE, no done.
  - Repeat with rst_n pulled low mid-HOLD → outputs clear asynchronously.
- Exhaustive round trip: sweep all legal (mode, num) pairs.
  - At hs_valid, popcount(hs) = num in mode 0, and hs = num in mode 1.
  - Feed hs into the hand-state-to-number converters and cross-check.

Source files
------------

// File: rtl/finger_count_encoder.sv
// finger_count_encoder
//
// Turns a number into a 5-bit hand-state pattern (bit0 = thumb .. bit4 = little finger).
// The fingers are raised one at a time, lowest first, every STEP_CYCLES cycles. The
// finished pattern is then held with o_hs_valid high for HOLD_CYCLES cycles, and o_done
// pulses for one cycle.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   i_valid    in   request strobe, accepted while o_ready is high
//   o_ready    out  high only in IDLE (decoded from state)
//   i_num      in   [3:0] number to show
//   i_mode     in   0 = unary (num raised fingers, num <= 5), 1 = binary pattern
//   i_abort    in   synchronous cancel of a running request
//   o_hs       out  [4:0] hand-state pattern
//   o_hs_valid out  high while the final pattern is held
//   o_done     out  one-cycle completion pulse
//   o_err      out  one-cycle pulse after a rejected (unary, num > 5) request

module finger_count_encoder #(
    parameter int unsigned STEP_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [3:0] i_num,
    input  logic       i_mode,
    input  logic       i_abort,
    output logic [4:0] o_hs,
    output logic       o_hs_valid,
    output logic       o_done,
    output logic       o_err
);

    localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRaise,
        StHold,
        StDone
    } state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [4:0]        r_target;
    logic [4:0]        w_target_d;
    logic [STEP_W-1:0] r_step_cnt;
    logic [STEP_W-1:0] w_step_cnt_d;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_cnt_d;
    logic [4:0]        r_hs;
    logic [4:0]        w_hs_d;
    logic              r_hs_valid;
    logic              w_hs_valid_d;
    logic              r_done;
    logic              w_done_d;
    logic              r_err;
    logic              w_err_d;

    logic              w_req_legal;
    logic [4:0]        w_req_target;
    logic [4:0]        w_remain;
    logic [4:0]        w_low_bit;
    logic [4:0]        w_hs_raised;
    logic              w_step_hit;
    logic              w_hold_hit;

    // Request decode: unary is a thermometer code of in_num ones.
    always_comb begin
        w_req_legal  = i_mode | (i_num <= 4'd5);
        w_req_target = 5'b00000;
        if (i_mode) begin
            w_req_target = {1'b0, i_num};
        end else begin
            case (i_num)
                4'd1:    w_req_target = 5'b00001;
                4'd2:    w_req_target = 5'b00011;
                4'd3:    w_req_target = 5'b00111;
                4'd4:    w_req_target = 5'b01111;
                4'd5:    w_req_target = 5'b11111;
                default: w_req_target = 5'b00000;
            endcase
        end
    end

    // Lowest target bit still missing from hs (x & -x isolates the lowest set bit).
    always_comb begin
        w_remain    = r_target & ~r_hs;
        w_low_bit   = w_remain & (~w_remain + 5'd1);
        w_hs_raised = r_hs | w_low_bit;
        w_step_hit  = (r_step_cnt == STEP_LAST);
        w_hold_hit  = (r_hold_cnt == HOLD_LAST);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_target   <= 5'b00000;
            r_step_cnt <= '0;
            r_hold_cnt <= '0;
            r_hs       <= 5'b00000;
            r_hs_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_target   <= w_target_d;
            r_step_cnt <= w_step_cnt_d;
            r_hold_cnt <= w_hold_cnt_d;
            r_hs       <= w_hs_d;
            r_hs_valid <= w_hs_valid_d;
            r_done     <= w_done_d;
            r_err      <= w_err_d;
        end
    end

    // Next-state logic; abort overrides every transition outside IDLE.
    always_comb begin
        w_state_d = r_state;
        if ((r_state != StIdle) && i_abort) begin
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_valid && w_req_legal) begin
                        w_state_d = (w_req_target == 5'b00000) ? StHold : StRaise;
                    end
                end
                StRaise: begin
                    if (w_step_hit && (w_hs_raised == r_target)) begin
                        w_state_d = StHold;
                    end
                end
                StHold: begin
                    if (w_hold_hit) begin
                        w_state_d = StDone;
                    end
                end
                StDone:  w_state_d = StIdle;
                default: w_state_d = StIdle;
            endcase
        end
    end

    // Datapath / registered-output next values. Flags are derived from the next state so
    // that they line up with the state they describe.
    always_comb begin
        w_target_d   = r_target;
        w_step_cnt_d = '0;
        w_hold_cnt_d = '0;
        w_hs_d       = r_hs;
        w_err_d      = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_hs_d = 5'b00000;
                if (i_valid) begin
                    if (w_req_legal) begin
                        w_target_d = w_req_target;
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
            end
            StRaise: begin
                if (w_step_hit) begin
                    w_hs_d = w_hs_raised;
                end else begin
                    w_step_cnt_d = r_step_cnt + 1'b1;
                end
            end
            StHold: begin
                w_hs_d       = r_target;
                w_hold_cnt_d = r_hold_cnt + 1'b1;
            end
            StDone: begin
                w_hs_d = r_target;
            end
            default: begin
                w_hs_d = 5'b00000;
            end
        endcase

        // Leaving for IDLE (done or abort) drops the hand and clears the counters.
        if (w_state_d == StIdle) begin
            w_hs_d = 5'b00000;
        end
        if (w_state_d != StRaise) begin
            w_step_cnt_d = '0;
        end
        if (w_state_d != StHold) begin
            w_hold_cnt_d = '0;
        end

        w_hs_valid_d = (w_state_d == StHold);
        w_done_d     = (w_state_d == StDone);
    end

    always_comb begin
        o_ready    = (r_state == StIdle);
        o_hs       = r_hs;
        o_hs_valid = r_hs_valid;
        o_done     = r_done;
        o_err      = r_err;
    end

endmodule

// File: tb/tb_finger_count_encoder.sv
module tb_finger_count_encoder;

    localparam int STEP = 2;
    localparam int HOLD = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [3:0] i_num = 4'd0;
    logic       i_mode = 1'b0;
    logic       i_abort = 1'b0;
    logic [4:0] o_hs;
    logic       o_hs_valid;
    logic       o_done;
    logic       o_err;

    int checks = 0;
    int failures = 0;

    finger_count_encoder #(
        .STEP_CYCLES(STEP),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_num     (i_num),
        .i_mode    (i_mode),
        .i_abort   (i_abort),
        .o_hs      (o_hs),
        .o_hs_valid(o_hs_valid),
        .o_done    (o_done),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: per-cycle expected output trace ----------------
    typedef struct packed {
        logic [4:0] hs;
        logic       hv;
        logic       dn;
        logic       er;
        logic       rd;
    } exp_t;

    localparam exp_t IDLE_E = '{hs: 5'd0, hv: 1'b0, dn: 1'b0, er: 1'b0, rd: 1'b1};

    exp_t q[$];
    exp_t cur = IDLE_E;

    function automatic exp_t mk(input logic [4:0] hs, input logic hv, input logic dn,
                                input logic er, input logic rd);
        exp_t e;
        e.hs = hs;
        e.hv = hv;
        e.dn = dn;
        e.er = er;
        e.rd = rd;
        return e;
    endfunction

    // Whole output trace for one request, from the cycle after the accepting edge.
    function automatic void build(input logic m, input logic [3:0] n);
        logic [4:0] t;
        logic [4:0] acc;
        if (!m && n > 4'd5) begin
            q.push_back(mk(5'd0, 1'b0, 1'b0, 1'b1, 1'b1));
            return;
        end
        t   = m ? {1'b0, n} : 5'((1 << n) - 1);
        acc = 5'd0;
        for (int b = 0; b < 5; b++) begin
            if (t[b]) begin
                for (int s = 0; s < STEP; s++) q.push_back(mk(acc, 1'b0, 1'b0, 1'b0, 1'b0));
                acc = acc | 5'(1 << b);
            end
        end
        for (int h = 0; h < HOLD; h++) q.push_back(mk(t, 1'b1, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(t, 1'b0, 1'b1, 1'b0, 1'b0));
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            if (cur.rd) begin
                if (i_valid) build(i_mode, i_num);
            end else if (i_abort) begin
                q.delete();
            end
        end
    end

    always @(negedge rst_n) begin
        q.delete();
        cur = IDLE_E;
    end

    // Compare process: one check per cycle of the full output vector.
    always @(negedge clk) begin
        cur = (q.size() > 0) ? q.pop_front() : IDLE_E;
        chk("cycle", 32'({o_hs, o_hs_valid, o_done, o_err, o_ready}), 32'(cur));
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input logic m, input logic [3:0] n);
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_mode  = m;
        i_num   = n;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_mode  = ~m;   // post-accept changes must be ignored
        i_num   = ~n;
    endtask

    task automatic wait_hv(output int lat);
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (o_hs_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic tail(input string nm);
        int hold = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!o_hs_valid) break;
            hold++;
        end
        chk({nm, " hold"}, 32'(hold), 32'(HOLD));
        chk({nm, " done"}, 32'(o_done), 32'd1);
        @(negedge clk);
        chk({nm, " idle"}, 32'({o_ready, o_hs, o_done}), 32'b1000000);
    endtask

    task automatic run(input logic m, input logic [3:0] n, input logic [4:0] exp_hs,
                       input int exp_lat, input string nm);
        int lat;
        logic [4:0] seen;
        send(m, n);
        wait_hv(lat);
        seen = o_hs;
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " hs"}, 32'(seen), 32'(exp_hs));
        if (m) chk({nm, " roundtrip"}, 32'(seen), 32'(n));
        else   chk({nm, " roundtrip"}, 32'($countones(seen)), 32'(n));
        tail(nm);
    endtask

    initial begin
        int lat;
        int dones;
        logic found;
        logic [4:0] t;

        #2 rst_n = 1'b0;
        #1;
        chk("reset outputs", 32'({o_hs, o_hs_valid, o_done, o_err, o_ready}), 32'b000000001);
        #19 rst_n = 1'b1;

        // Hand-computed literal expectations.
        run(1'b0, 4'd3, 5'b00111, 7, "unary3");
        run(1'b1, 4'd10, 5'b01010, 5, "binary10");
        run(1'b0, 4'd0, 5'b00000, 1, "zero");

        // Illegal request, then a request in the err cycle.
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_mode  = 1'b0;
        i_num   = 4'd7;
        @(posedge clk);
        #1;
        i_mode = 1'b1;
        i_num  = 4'd1;
        @(negedge clk);
        chk("illegal err", 32'({o_err, o_ready, o_hs}), 32'b11_00000);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        wait_hv(lat);
        chk("after err latency", 32'(lat), 32'd3);
        chk("after err hs", 32'(o_hs), 32'b00001);
        tail("after err");

        // Abort after the second raise.
        send(1'b0, 4'd5);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_hs == 5'b00011) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort reach 00011", 32'(found), 32'd1);
        i_abort = 1'b1;
        @(posedge clk);
        #1;
        i_abort = 1'b0;
        chk("abort clears", 32'({o_ready, o_hs, o_hs_valid}), 32'b1_00000_0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o_done) dones++;
        end
        chk("abort no done", 32'(dones), 32'd0);

        // Abort in IDLE together with a request: request still taken.
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_abort = 1'b1;
        i_mode  = 1'b1;
        i_num   = 4'd4;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_abort = 1'b0;
        wait_hv(lat);
        chk("idle abort latency", 32'(lat), 32'd3);
        chk("idle abort hs", 32'(o_hs), 32'b00100);
        tail("idle abort");

        // Reset mid-HOLD.
        send(1'b0, 4'd2);
        wait_hv(lat);
        chk("pre-reset hold", 32'({o_hs_valid, o_hs}), 32'b1_00011);
        #2 rst_n = 1'b0;
        #1;
        chk("mid reset", 32'({o_hs, o_hs_valid, o_done, o_err, o_ready}), 32'b000000001);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Sweep every legal (mode, num) pair.
        for (int m = 0; m < 2; m++) begin
            for (int n = 0; n < ((m == 1) ? 16 : 6); n++) begin
                t = (m == 1) ? 5'(n) : 5'((1 << n) - 1);
                run(m[0], 4'(n), t, $countones(t) * STEP + 1, "sweep");
            end
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
